// File: rtl/ftoi_pkg.sv
// Shared types and constants for the binary32 -> integer converter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ftoi_pkg;

    typedef enum logic [1:0] {
        RTZ = 2'b00,
        RNE = 2'b01,
        RDN = 2'b10,
        RUP = 2'b11
    } rm_t;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;

    // Per-operand side information carried from S1 to S2 next to the magnitude.
    typedef struct packed {
        logic sign;     // operand sign bit
        logic uns;      // unsigned result requested
        rm_t  rm;       // rounding mode
        logic nan;      // operand is NaN
        logic big;      // magnitude >= 2^OUT_W (includes infinity)
        logic guard;    // first dropped fraction bit
        logic sticky;   // OR of all lower dropped fraction bits
        logic den_nx;   // denormal with nonzero mantissa, flushed to zero
    } s1_meta_t;

    // Decide whether the truncated magnitude must be incremented.
    function automatic logic round_up(input rm_t rm, input logic neg,
                                      input logic lsb, input logic g, input logic s);
        logic r;
        r = 1'b0;
        case (rm)
            RTZ: r = 1'b0;
            RNE: r = g & (s | lsb);
            RDN: r = neg & (g | s);
            RUP: r = ~neg & (g | s);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ftoi_align.sv
// S1 alignment: shifts the significand so the binary point sits below bit 0.
// Latency: purely combinational.
// Backpressure: none (no state).
// Ports: x_abs = operand without sign; mag = integer part (truncated);
//        guard/sticky = dropped fraction bits; too_big = |x| >= 2^OUT_W or inf/NaN;
//        is_nan = NaN operand; den_nx = nonzero denormal (flushed to zero).
module ftoi_align
    import ftoi_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic [30:0]      x_abs,
    output logic [OUT_W-1:0] mag,
    output logic             guard,
    output logic             sticky,
    output logic             too_big,
    output logic             is_nan,
    output logic             den_nx
);

    // Wide enough that any in-range left shift keeps every significand bit.
    localparam int XW = OUT_W + MAN_W + 1;

    logic [EXP_W-1:0]       exp_f;
    logic [MAN_W-1:0]       man;
    logic [MAN_W:0]         sig;
    logic signed [9:0]      e_unb;
    logic [9:0]             sh_l;
    logic [9:0]             sh_r;
    logic [XW-1:0]          wide;
    logic [2*MAN_W+1:0]     fx;

    assign exp_f = x_abs[30:23];
    assign man   = x_abs[22:0];
    assign sig   = {1'b1, man};
    assign e_unb = $signed({2'b00, exp_f}) - $signed(10'(EXP_BIAS));
    assign sh_l  = e_unb - 10'sd23;
    assign sh_r  = 10'sd23 - e_unb;

    always_comb begin
        wide   = '0;
        fx     = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        if (exp_f == '0) begin
            // Denormal or zero: flushed, inexactness reported through den_nx.
            wide = '0;
        end else if (e_unb >= 10'sd23) begin
            wide = XW'(sig) << sh_l;
        end else if (e_unb >= -10'sd1) begin
            // Right shift by 1..24; the shifted-out bits land in the low half.
            fx     = {sig, 24'b0} >> sh_r;
            wide   = XW'(fx[2*MAN_W+1:MAN_W+1]);
            guard  = fx[MAN_W];
            sticky = |fx[MAN_W-1:0];
        end else begin
            // |x| < 0.5 and nonzero: below the guard position entirely.
            sticky = 1'b1;
        end
    end

    assign mag     = wide[OUT_W-1:0];
    assign too_big = (e_unb >= $signed(10'(OUT_W))) || (|wide[XW-1:OUT_W]);
    assign is_nan  = (&exp_f) && (|man);
    assign den_nx  = (exp_f == '0) && (|man);

endmodule

// File: rtl/ftoi_pipe.sv
// Binary32 to signed/unsigned integer converter, 2-stage pipeline (S1 align, S2 round/saturate).
// Latency: operand captured at edge N, result out_valid after edge N+1; one operand per cycle.
// Backpressure: S2 holds while out_valid && !out_ready, S1 holds behind it; in_ready = !s1_vld || S2 advances.
// Ports: clk/rstn (async active-low); in_valid/in_ready/in_x/in_rm/in_uns operand side;
//        out_valid/out_ready/out_y/out_ovf/out_nx result side.
module ftoi_pipe
    import ftoi_pkg::*;
#(
    parameter int OUT_W      = 32,
    parameter int SIGNED_DEF = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  rm_t              in_rm,
    input  logic             in_uns,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_y,
    output logic             out_ovf,
    output logic             out_nx
);

    localparam logic [OUT_W-1:0] SMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SMIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] UMAX = {OUT_W{1'b1}};

    logic [OUT_W-1:0] a_mag;
    logic             a_guard, a_sticky, a_big, a_nan, a_den_nx;

    logic             s1_vld;
    logic [OUT_W-1:0] s1_mag;
    s1_meta_t         s1_meta;
    logic             s2_adv;

    logic             inc;
    logic [OUT_W:0]   rmag;
    logic [OUT_W-1:0] y_n;
    logic             ovf_n, nx_n;

    ftoi_align #(.OUT_W(OUT_W)) u_align (
        .x_abs   (in_x[30:0]),
        .mag     (a_mag),
        .guard   (a_guard),
        .sticky  (a_sticky),
        .too_big (a_big),
        .is_nan  (a_nan),
        .den_nx  (a_den_nx)
    );

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_vld || s2_adv;

    // ---------------- S1 ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld      <= 1'b0;
            s1_mag      <= '0;
            s1_meta     <= '0;
            s1_meta.uns <= (SIGNED_DEF == 0);
        end else if (in_ready) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_mag         <= a_mag;
                s1_meta.sign   <= in_x[31];
                s1_meta.uns    <= in_uns;
                s1_meta.rm     <= in_rm;
                s1_meta.nan    <= a_nan;
                s1_meta.big    <= a_big;
                s1_meta.guard  <= a_guard;
                s1_meta.sticky <= a_sticky;
                s1_meta.den_nx <= a_den_nx;
            end
        end
    end

    // ---------------- S2 combinational: round, range check, negate ----------------
    always_comb begin
        inc   = round_up(s1_meta.rm, s1_meta.sign, s1_mag[0], s1_meta.guard, s1_meta.sticky);
        // One extra bit so a rounding carry out of the top is seen by the range check.
        rmag  = {1'b0, s1_mag} + {{OUT_W{1'b0}}, inc};
        y_n   = '0;
        ovf_n = 1'b0;
        nx_n  = s1_meta.guard | s1_meta.sticky | s1_meta.den_nx;
        if (s1_meta.nan) begin
            y_n   = s1_meta.uns ? UMAX : SMAX;
            ovf_n = 1'b1;
            nx_n  = 1'b0;
        end else if (s1_meta.big) begin
            y_n   = s1_meta.sign ? (s1_meta.uns ? '0 : SMIN) : (s1_meta.uns ? UMAX : SMAX);
            ovf_n = 1'b1;
            nx_n  = 1'b0;
        end else if (s1_meta.uns) begin
            if (s1_meta.sign) begin
                // Only a negative value that rounds to zero is representable.
                if (rmag != '0) begin
                    ovf_n = 1'b1;
                    nx_n  = 1'b0;
                end
            end else if (rmag[OUT_W]) begin
                y_n   = UMAX;
                ovf_n = 1'b1;
                nx_n  = 1'b0;
            end else begin
                y_n = rmag[OUT_W-1:0];
            end
        end else if (s1_meta.sign) begin
            // Magnitude 2^(OUT_W-1) is still legal on the negative side.
            if (rmag[OUT_W] || (rmag[OUT_W-1] && (|rmag[OUT_W-2:0]))) begin
                y_n   = SMIN;
                ovf_n = 1'b1;
                nx_n  = 1'b0;
            end else begin
                y_n = '0 - rmag[OUT_W-1:0];
            end
        end else if (rmag[OUT_W] || rmag[OUT_W-1]) begin
            y_n   = SMAX;
            ovf_n = 1'b1;
            nx_n  = 1'b0;
        end else begin
            y_n = rmag[OUT_W-1:0];
        end
    end

    // ---------------- S2 register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_ovf   <= 1'b0;
            out_nx    <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_y   <= y_n;
                out_ovf <= ovf_n;
                out_nx  <= nx_n;
            end
        end
    end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Directed and swept checks of ftoi_pipe at OUT_W=32 and OUT_W=64 driven in lockstep.
// Latency: n/a (testbench).
// Backpressure: out_ready driven by the bench.
module tb_ftoi_pipe;
    import ftoi_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [31:0] in_x;
    rm_t         in_rm;
    logic        in_uns;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_ovf32, out_nx32;
    logic [31:0] out_y32;
    logic        in_ready64, out_valid64, out_ovf64, out_nx64;
    logic [63:0] out_y64;

    int checks = 0;
    int errors = 0;

    logic [31:0] op_x   [512];
    logic [1:0]  op_rm  [512];
    logic        op_uns [512];
    logic [63:0] e32_y  [512];
    logic        e32_ovf[512];
    logic        e32_nx [512];
    logic [63:0] e64_y  [512];
    logic        e64_ovf[512];
    logic        e64_nx [512];

    always #5 clk = ~clk;

    ftoi_pipe #(.OUT_W(32), .SIGNED_DEF(1)) u_dut32 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready32),
        .in_x(in_x), .in_rm(in_rm), .in_uns(in_uns),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_y(out_y32), .out_ovf(out_ovf32), .out_nx(out_nx32)
    );

    ftoi_pipe #(.OUT_W(64), .SIGNED_DEF(1)) u_dut64 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready64),
        .in_x(in_x), .in_rm(in_rm), .in_uns(in_uns),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_y(out_y64), .out_ovf(out_ovf64), .out_nx(out_nx64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference conversion using real arithmetic on the decoded operand value.
    function automatic void model(input logic [31:0] x, input logic [1:0] rm, input logic uns,
                                  input int w, output logic [63:0] y, output logic ovf,
                                  output logic nx);
        real v, r, fl, d, lo, hi;
        logic [63:0] smax, smin, umax;
        int e;
        smax = (w == 64) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h0000_0000_7FFF_FFFF;
        smin = (w == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
        umax = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        e = int'(x[30:23]);
        y = '0; ovf = 1'b0; nx = 1'b0;
        if (e == 255) begin
            ovf = 1'b1;
            if (x[22:0] != 0) y = uns ? umax : smax;
            else              y = x[31] ? (uns ? 64'd0 : smin) : (uns ? umax : smax);
        end else if (e == 0) begin
            nx = (x[22:0] != 0);
        end else begin
            v = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
            if (x[31]) v = -v;
            fl = $floor(v);
            case (rm)
                2'b00: r = (v >= 0.0) ? fl : $ceil(v);
                2'b10: r = fl;
                2'b11: r = $ceil(v);
                default: begin
                    d = v - fl;
                    if (d > 0.5)      r = fl + 1.0;
                    else if (d < 0.5) r = fl;
                    else              r = ($floor(fl / 2.0) * 2.0 == fl) ? fl : fl + 1.0;
                end
            endcase
            nx = (r != v);
            lo = uns ? 0.0 : -(2.0 ** (w - 1));
            hi = uns ? (2.0 ** w) - 1.0 : (2.0 ** (w - 1)) - 1.0;
            if (r < lo) begin
                y = uns ? 64'd0 : smin; ovf = 1'b1; nx = 1'b0;
            end else if (r > hi) begin
                y = uns ? umax : smax; ovf = 1'b1; nx = 1'b0;
            end else if (r >= 9223372036854775808.0) begin
                y = 64'(longint'(r - 9223372036854775808.0)) ^ 64'h8000_0000_0000_0000;
            end else begin
                y = 64'(longint'(r));
            end
            if (w == 32) y = {32'd0, y[31:0]};
        end
    endfunction

    // Directed entry: hand-derived 32-bit expectations, 64-bit from the reference model.
    task automatic set_op(input int i, input logic [31:0] x, input logic [1:0] rm, input logic uns,
                          input logic [31:0] y, input logic ovf, input logic nx);
        op_x[i] = x; op_rm[i] = rm; op_uns[i] = uns;
        e32_y[i] = {32'd0, y}; e32_ovf[i] = ovf; e32_nx[i] = nx;
        model(x, rm, uns, 64, e64_y[i], e64_ovf[i], e64_nx[i]);
    endtask

    task automatic set_rand(input int i, input logic [31:0] x, input logic [1:0] rm, input logic uns);
        op_x[i] = x; op_rm[i] = rm; op_uns[i] = uns;
        model(x, rm, uns, 32, e32_y[i], e32_ovf[i], e32_nx[i]);
        model(x, rm, uns, 64, e64_y[i], e64_ovf[i], e64_nx[i]);
    endtask

    // Streams n operands; out_ready is held low for the first 'stall' cycles. Called at a negedge.
    task automatic run_ops(input int n, input int stall);
        int acc = 0, got = 0, cyc = 0;
        int acc_at[512];
        logic [63:0] held = '0;
        logic        have_held = 1'b0;
        while (got < n && cyc < n + stall + 20) begin
            out_ready = (cyc >= stall);
            in_valid  = (acc < n);
            if (acc < n) begin
                in_x = op_x[acc]; in_rm = rm_t'(op_rm[acc]); in_uns = op_uns[acc];
            end
            #1;
            if (stall > 0 && cyc == stall - 1) begin
                check("bp_accepted", 64'(acc), 64'd2);
                check("bp_in_ready_low", 64'(in_ready32), 64'd0);
            end
            if (out_valid32 && !out_ready) begin
                if (have_held) check("stall_hold_y", 64'(out_y32), held);
                held = 64'(out_y32);
                have_held = 1'b1;
            end
            if (out_valid32 && out_ready) begin
                check($sformatf("y32[%0d]", got),   64'(out_y32),   e32_y[got]);
                check($sformatf("ovf32[%0d]", got), 64'(out_ovf32), 64'(e32_ovf[got]));
                check($sformatf("nx32[%0d]", got),  64'(out_nx32),  64'(e32_nx[got]));
                check($sformatf("vld64[%0d]", got), 64'(out_valid64), 64'd1);
                check($sformatf("y64[%0d]", got),   out_y64,        e64_y[got]);
                check($sformatf("ovf64[%0d]", got), 64'(out_ovf64), 64'(e64_ovf[got]));
                check($sformatf("nx64[%0d]", got),  64'(out_nx64),  64'(e64_nx[got]));
                if (stall == 0) check($sformatf("latency[%0d]", got), 64'(cyc - acc_at[got]), 64'd2);
                got++;
            end
            if (in_valid && in_ready32) begin
                acc_at[acc] = cyc;
                acc++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        if (got < n) check("stream_timeout_results", 64'(got), 64'(n));
    endtask

    initial begin
        logic [31:0] x;
        rstn = 1'b0; in_valid = 1'b0; in_x = '0; in_rm = RTZ; in_uns = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid32), 64'd0);
        check("rst_in_ready",  64'(in_ready32),  64'd1);
        check("rst_out_y",     64'(out_y32),     64'd0);
        check("rst_out_ovf",   64'(out_ovf32),   64'd0);
        check("rst_out_nx",    64'(out_nx32),    64'd0);
        check("rst_out_y64",   out_y64,          64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed vectors, streamed back to back.
        set_op(0,  32'h3FC00000, 2'b01, 1'b0, 32'h00000002, 1'b0, 1'b1); // 1.5 RNE
        set_op(1,  32'h3FC00000, 2'b00, 1'b0, 32'h00000001, 1'b0, 1'b1); // 1.5 RTZ
        set_op(2,  32'h40200000, 2'b01, 1'b0, 32'h00000002, 1'b0, 1'b1); // 2.5 RNE
        set_op(3,  32'hC0200000, 2'b10, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b1); // -2.5 RDN
        set_op(4,  32'hC0200000, 2'b11, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1); // -2.5 RUP
        set_op(5,  32'h4F000000, 2'b00, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0); // 2^31
        set_op(6,  32'hCF000000, 2'b00, 1'b0, 32'h80000000, 1'b0, 1'b0); // -2^31
        set_op(7,  32'h7FC00000, 2'b01, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0); // NaN
        set_op(8,  32'hFF800000, 2'b01, 1'b0, 32'h80000000, 1'b1, 1'b0); // -inf
        set_op(9,  32'hBF800000, 2'b00, 1'b1, 32'h00000000, 1'b1, 1'b0); // -1 unsigned
        set_op(10, 32'hBE99999A, 2'b00, 1'b1, 32'h00000000, 1'b0, 1'b1); // -0.3 unsigned RTZ
        set_op(11, 32'h4F800000, 2'b00, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0); // 2^32 unsigned
        set_op(12, 32'h00400000, 2'b11, 1'b0, 32'h00000000, 1'b0, 1'b1); // denormal RUP
        set_op(13, 32'h80000000, 2'b11, 1'b0, 32'h00000000, 1'b0, 1'b0); // -0
        set_op(14, 32'h3F000000, 2'b01, 1'b0, 32'h00000000, 1'b0, 1'b1); // 0.5 RNE
        set_op(15, 32'h3F000000, 2'b11, 1'b0, 32'h00000001, 1'b0, 1'b1); // 0.5 RUP
        set_op(16, 32'hBF000000, 2'b10, 1'b1, 32'h00000000, 1'b1, 1'b0); // -0.5 RDN unsigned
        set_op(17, 32'h3FF00000, 2'b01, 1'b0, 32'h00000002, 1'b0, 1'b1); // 1.875 RNE carry
        set_op(18, 32'h4EFFFFFF, 2'b01, 1'b0, 32'h7FFFFF80, 1'b0, 1'b0); // largest < 2^31
        set_op(19, 32'h7F800000, 2'b00, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0); // +inf unsigned
        run_ops(20, 0);

        // Backpressure: four operands, out_ready low for five cycles.
        set_op(0, 32'h3FC00000, 2'b01, 1'b0, 32'h00000002, 1'b0, 1'b1);
        set_op(1, 32'hC0200000, 2'b10, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b1);
        set_op(2, 32'h40200000, 2'b01, 1'b0, 32'h00000002, 1'b0, 1'b1);
        set_op(3, 32'hCF000000, 2'b00, 1'b0, 32'h80000000, 1'b0, 1'b0);
        run_ops(4, 5);

        // Reset with two operands in flight.
        out_ready = 1'b0; in_valid = 1'b1;
        in_x = 32'h3FC00000; in_rm = RNE; in_uns = 1'b0;
        @(negedge clk);
        in_x = 32'h40200000;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre_rst_out_valid", 64'(out_valid32), 64'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid32), 64'd0);
        check("mid_rst_in_ready",  64'(in_ready32),  64'd1);
        check("mid_rst_out_y",     64'(out_y32),     64'd0);
        check("mid_rst_out_valid64", 64'(out_valid64), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        set_op(0, 32'h3FC00000, 2'b00, 1'b0, 32'h00000001, 1'b0, 1'b1);
        run_ops(1, 0);
        #1;
        check("post_rst_idle", 64'(out_valid32), 64'd0);
        @(negedge clk);

        // Every biased exponent 1..254 with random sign, mantissa, mode and signedness.
        for (int i = 0; i < 254; i++) begin
            x = {1'($urandom_range(0, 1)), 8'(i + 1), 23'($urandom)};
            set_rand(i, x, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        run_ops(254, 0);

        // Random sweep weighted toward exponents that land near the integer range.
        for (int i = 0; i < 300; i++) begin
            x = {1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 254)) : 8'($urandom_range(120, 192)),
                 23'($urandom)};
            set_rand(i, x, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        run_ops(300, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
